// File: rtl/chimp_test_control.sv
// -----------------------------------------------------------------------------
// chimp_test_control
//
// Sequencing controller for the chimp-test board datapath. It clears the 8x8
// board, lets the datapath load random numbers, shows the numbers until the
// first correct click, and then forwards player clicks one at a time. While it
// does this it tracks the expected number, the level, the strikes and the score.
//
// Ports
//   clk               system clock
//   iReset            synchronous active-high reset, has priority in every state
//   iStart            start/restart pulse, honoured only in IDLE and GAME_OVER
//   iMouseClick       one-cycle click pulse from the mouse front end
//   iDoneLoad         datapath flag: board fully loaded
//   iChoseCorrectNum  datapath verdict: clicked cell held the expected number
//   iChoseWrongNum    datapath verdict: wrong cell (wins over correct)
//   oResetBoard       board clear to datapath (exactly 2 cycles per CLEAR)
//   oLoadEnable       load enable to datapath (high throughout LOAD)
//   oShowEnable       show-numbers enable to datapath
//   oMouseClick       gated one-cycle click to datapath
//   oLevel            current level (highest number on the board)
//   oNumToChoose      next number the player must click
//   oStrikes          wrong answers in this game
//   oScore            levels completed in this game (saturates at 31)
//   oGameOver         game finished
//   oState            encoded state for debug/LED display
//
// Every output is registered. The enables and strobes are computed from the
// next state, so each one is high in exactly the cycles the FSM spends in the
// matching state.
// -----------------------------------------------------------------------------
module chimp_test_control #(
  parameter int START_LEVEL    = 3,
  parameter int MAX_LEVEL      = 24,
  parameter int MAX_STRIKES    = 3,
  parameter int LOAD_TIMEOUT   = 4096,
  parameter int RESULT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iMouseClick,
  input  logic       iDoneLoad,
  input  logic       iChoseCorrectNum,
  input  logic       iChoseWrongNum,
  output logic       oResetBoard,
  output logic       oLoadEnable,
  output logic       oShowEnable,
  output logic       oMouseClick,
  output logic [4:0] oLevel,
  output logic [4:0] oNumToChoose,
  output logic [1:0] oStrikes,
  output logic [4:0] oScore,
  output logic       oGameOver,
  output logic [2:0] oState
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    LOAD       = 3'd2,
    PLAY       = 3'd3,
    WAIT_RES   = 3'd4,
    LEVEL_DONE = 3'd5,
    GAME_OVER  = 3'd6
  } stateType;

  // One shared counter times CLEAR, LOAD and WAIT_RES. It restarts at zero on
  // every state change, so each of those states sees 0 in its first cycle.
  localparam int CNT_MAX = (LOAD_TIMEOUT > RESULT_TIMEOUT) ? LOAD_TIMEOUT : RESULT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(1);                  // 2 cycles of CLEAR
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_TIMEOUT - 1);

  localparam logic [4:0] START_LVL    = 5'(START_LEVEL);
  localparam logic [4:0] MAX_LVL      = 5'(MAX_LEVEL);
  localparam logic [1:0] STRIKE_LIMIT = 2'(MAX_STRIKES);
  localparam logic [4:0] SCORE_MAX    = 5'd31;

  stateType         state;
  stateType         stateNext;
  logic [CNT_W-1:0] stateCycles;

  logic [4:0] levelNext;
  logic [4:0] numNext;
  logic [1:0] strikesNext;
  logic [4:0] scoreNext;
  logic       showNext;
  logic       clickNext;

  assign oState = state;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    stateNext   = state;
    levelNext   = oLevel;
    numNext     = oNumToChoose;
    strikesNext = oStrikes;
    scoreNext   = oScore;
    showNext    = oShowEnable;
    clickNext   = 1'b0;

    unique case (state)
      IDLE, GAME_OVER: begin
        if (iStart) begin
          levelNext   = START_LVL;
          strikesNext = 2'd0;
          scoreNext   = 5'd0;
          stateNext   = CLEAR;
        end
      end

      CLEAR: begin
        // Cleared here rather than on entry, so the cycle right after a verdict
        // still shows the number that was being chosen.
        numNext  = 5'd0;
        showNext = 1'b0;
        if (stateCycles == CLEAR_LAST) begin
          stateNext = LOAD;
        end
      end

      LOAD: begin
        if (iDoneLoad) begin
          showNext  = 1'b1;
          stateNext = PLAY;
        end else if (stateCycles == LOAD_LAST) begin
          // The datapath never finished loading: wipe the board and try again
          // without touching level or strikes.
          stateNext = CLEAR;
        end
      end

      PLAY: begin
        if (iMouseClick) begin
          clickNext = 1'b1;
          stateNext = WAIT_RES;
        end
      end

      WAIT_RES: begin
        // Clicks arriving here are dropped, not queued. A wrong verdict beats a
        // simultaneous correct one, and a correct one beats the timeout.
        if (iChoseWrongNum || (!iChoseCorrectNum && stateCycles == RESULT_LAST)) begin
          strikesNext = oStrikes + 2'd1;
          stateNext   = (strikesNext == STRIKE_LIMIT) ? GAME_OVER : CLEAR;
        end else if (iChoseCorrectNum) begin
          showNext = 1'b0;
          if (oNumToChoose == oLevel) begin
            stateNext = LEVEL_DONE;
          end else begin
            numNext   = oNumToChoose + 5'd1;
            stateNext = PLAY;
          end
        end
      end

      LEVEL_DONE: begin
        scoreNext = (oScore == SCORE_MAX) ? oScore : oScore + 5'd1;
        if (oLevel == MAX_LVL) begin
          stateNext = GAME_OVER;
        end else begin
          levelNext = oLevel + 5'd1;
          stateNext = CLEAR;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    // Reveal the board whenever the game ends, whatever ended it.
    if (stateNext == GAME_OVER) begin
      showNext = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and tested first, so it overrides
    // whatever the FSM was doing, including mid-load and mid-verdict.
    if (iReset) begin
      state        <= IDLE;
      stateCycles  <= '0;
      oLevel       <= START_LVL;
      oNumToChoose <= 5'd0;
      oStrikes     <= 2'd0;
      oScore       <= 5'd0;
      oShowEnable  <= 1'b0;
      oResetBoard  <= 1'b0;
      oLoadEnable  <= 1'b0;
      oMouseClick  <= 1'b0;
      oGameOver    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // values from before this edge regardless of statement order.
      state        <= stateNext;
      stateCycles  <= (stateNext != state) ? '0 : stateCycles + CNT_W'(1);
      oLevel       <= levelNext;
      oNumToChoose <= numNext;
      oStrikes     <= strikesNext;
      oScore       <= scoreNext;
      oShowEnable  <= showNext;
      oResetBoard  <= (stateNext == CLEAR);
      oLoadEnable  <= (stateNext == LOAD);
      oMouseClick  <= clickNext;
      oGameOver    <= (stateNext == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_chimp_test_control.sv
// -----------------------------------------------------------------------------
// tb_chimp_test_control
//
// Self-checking bench for chimp_test_control. A behavioural model of the game
// rules advances once per clock edge on the same inputs as the DUT, and every
// DUT output is compared against it 1 ns after each rising edge. Directed
// scenarios are followed by a perfect game up to the last level and a stretch
// of random stimulus.
// -----------------------------------------------------------------------------
module tb_chimp_test_control;

  localparam int START_LEVEL    = 3;
  localparam int MAX_LEVEL      = 24;
  localparam int MAX_STRIKES    = 3;
  localparam int LOAD_TIMEOUT   = 4096;
  localparam int RESULT_TIMEOUT = 16;

  // Spec state encodings, as seen on oState
  localparam int S_IDLE = 0, S_CLEAR = 1, S_LOAD = 2, S_PLAY = 3,
                 S_WAIT = 4, S_DONE = 5, S_OVER = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       iReset = 1'b0, iStart = 1'b0, iMouseClick = 1'b0;
  logic       iDoneLoad = 1'b0, iChoseCorrectNum = 1'b0, iChoseWrongNum = 1'b0;
  logic       oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver;
  logic [4:0] oLevel, oNumToChoose, oScore;
  logic [1:0] oStrikes;
  logic [2:0] oState;

  chimp_test_control #(
    .START_LEVEL(START_LEVEL), .MAX_LEVEL(MAX_LEVEL), .MAX_STRIKES(MAX_STRIKES),
    .LOAD_TIMEOUT(LOAD_TIMEOUT), .RESULT_TIMEOUT(RESULT_TIMEOUT)
  ) dut (
    .clk(clk), .iReset(iReset), .iStart(iStart), .iMouseClick(iMouseClick),
    .iDoneLoad(iDoneLoad), .iChoseCorrectNum(iChoseCorrectNum),
    .iChoseWrongNum(iChoseWrongNum), .oResetBoard(oResetBoard),
    .oLoadEnable(oLoadEnable), .oShowEnable(oShowEnable), .oMouseClick(oMouseClick),
    .oLevel(oLevel), .oNumToChoose(oNumToChoose), .oStrikes(oStrikes),
    .oScore(oScore), .oGameOver(oGameOver), .oState(oState)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: game rules in plain integer arithmetic
  // ---------------------------------------------------------------------------
  int mState, mLevel, mNum, mStrikes, mScore, mShow, mClick;
  int clearLeft;   // CLEAR cycles still to go
  int loadCycles;  // cycles spent in LOAD so far
  int waitCycles;  // cycles spent waiting for a verdict so far

  task automatic modelReset();
    mState = S_IDLE; mLevel = START_LEVEL; mNum = 0; mStrikes = 0; mScore = 0;
    mShow = 0; mClick = 0; clearLeft = 0; loadCycles = 0; waitCycles = 0;
  endtask

  task automatic enterClear();
    mState = S_CLEAR; clearLeft = 2;
  endtask

  task automatic endGame();
    mState = S_OVER; mShow = 1;
  endtask

  task automatic newGame();
    mLevel = START_LEVEL; mStrikes = 0; mScore = 0;
    enterClear();
  endtask

  task automatic takeStrike();
    mStrikes++;
    if (mStrikes == MAX_STRIKES) endGame();
    else enterClear();
  endtask

  task automatic modelStep(input bit rst, input bit st, input bit ck,
                           input bit dn, input bit cr, input bit wr);
    mClick = 0;
    if (rst) begin
      modelReset();
      return;
    end
    case (mState)
      S_IDLE, S_OVER: if (st) newGame();
      S_CLEAR: begin
        mNum = 0; mShow = 0; clearLeft--;
        if (clearLeft == 0) begin mState = S_LOAD; loadCycles = 0; end
      end
      S_LOAD: begin
        loadCycles++;
        if (dn) begin mState = S_PLAY; mShow = 1; end
        else if (loadCycles == LOAD_TIMEOUT) enterClear();
      end
      S_PLAY: if (ck) begin mClick = 1; mState = S_WAIT; waitCycles = 0; end
      S_WAIT: begin
        waitCycles++;
        if (wr) takeStrike();
        else if (cr) begin
          mShow = 0;
          if (mNum == mLevel) mState = S_DONE;
          else begin mNum++; mState = S_PLAY; end
        end else if (waitCycles == RESULT_TIMEOUT) takeStrike();
      end
      S_DONE: begin
        mScore = (mScore < 31) ? mScore + 1 : 31;
        if (mLevel == MAX_LEVEL) endGame();
        else begin mLevel++; enterClear(); end
      end
      default: ;
    endcase
  endtask

  task automatic compareAll();
    check("state",      int'(oState),       mState);
    check("level",      int'(oLevel),       mLevel);
    check("num",        int'(oNumToChoose), mNum);
    check("strikes",    int'(oStrikes),     mStrikes);
    check("score",      int'(oScore),       mScore);
    check("show",       int'(oShowEnable),  mShow);
    check("click",      int'(oMouseClick),  mClick);
    check("gameover",   int'(oGameOver),    int'(mState == S_OVER));
    check("resetboard", int'(oResetBoard),  int'(mState == S_CLEAR));
    check("loadenable", int'(oLoadEnable),  int'(mState == S_LOAD));
    check("one_hot_rb_le", int'(oResetBoard & oLoadEnable), 0);
  endtask

  // Drive one cycle of inputs, clock it into DUT and model, then compare.
  task automatic tick(input bit rst, input bit st, input bit ck,
                      input bit dn, input bit cr, input bit wr);
    iReset = rst; iStart = st; iMouseClick = ck;
    iDoneLoad = dn; iChoseCorrectNum = cr; iChoseWrongNum = wr;
    @(posedge clk);
    modelStep(rst, st, ck, dn, cr, wr);
    #1;
    compareAll();
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0);
  endtask

  // From the first CLEAR cycle: finish CLEAR, spend `extra` more cycles in
  // LOAD, then report the board loaded.
  task automatic loadBoard(input int extra);
    idle(); idle();
    repeat (extra) idle();
    tick(0, 0, 0, 1, 0, 0);
  endtask

  int rbCount, clickCount;

  initial begin
    modelReset();

    // Reset values
    tick(1, 0, 0, 0, 0, 0);
    check("rst_state", int'(oState), S_IDLE);
    check("rst_level", int'(oLevel), 3);
    check("rst_score", int'(oScore), 0);
    check("rst_gameover", int'(oGameOver), 0);

    // Start, 2 CLEAR cycles, 5 LOAD cycles, then loaded
    rbCount = 0;
    tick(0, 1, 0, 0, 0, 0); rbCount += int'(oResetBoard);
    idle();                 rbCount += int'(oResetBoard);
    idle();                 rbCount += int'(oResetBoard);
    check("load_on", int'(oLoadEnable), 1);
    repeat (4) begin idle(); rbCount += int'(oResetBoard); end
    check("load_still_on", int'(oLoadEnable), 1);
    tick(0, 0, 0, 1, 0, 0);
    check("rb_two_cycles", rbCount, 2);
    check("load_off", int'(oLoadEnable), 0);
    check("show_after_load", int'(oShowEnable), 1);
    check("play_level", int'(oLevel), 3);
    check("play_state", int'(oState), S_PLAY);

    // Level 3: four correct clicks
    for (int k = 0; k < 4; k++) begin
      check("num_before_click", int'(oNumToChoose), k);
      tick(0, 0, 1, 0, 0, 0);
      check("click_fwd", int'(oMouseClick), 1);
      tick(0, 0, 0, 0, 1, 0);
      check("show_hidden", int'(oShowEnable), 0);
    end
    check("lvl_done_state", int'(oState), S_DONE);
    idle();
    check("score_1", int'(oScore), 1);
    check("level_4", int'(oLevel), 4);
    check("after_done_clear", int'(oState), S_CLEAR);

    // Three wrong verdicts at level 3
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    loadBoard(3);
    for (int s = 1; s <= 3; s++) begin
      tick(0, 0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1);
      if (s < 3) begin
        check("strike_clear", int'(oState), S_CLEAR);
        check("strike_level", int'(oLevel), 3);
        check("strike_count", int'(oStrikes), s);
        loadBoard(0);
      end
    end
    check("over_state", int'(oState), S_OVER);
    check("over_flag", int'(oGameOver), 1);
    check("over_show", int'(oShowEnable), 1);
    check("over_strikes", int'(oStrikes), 3);

    // Restart; dropped second click and verdict timeout
    tick(0, 1, 0, 0, 0, 0);
    check("restart_strikes", int'(oStrikes), 0);
    check("restart_gameover", int'(oGameOver), 0);
    loadBoard(2);
    clickCount = 0;
    tick(0, 0, 1, 0, 0, 0); clickCount += int'(oMouseClick);
    tick(0, 0, 1, 0, 0, 0); clickCount += int'(oMouseClick);
    repeat (14) begin idle(); clickCount += int'(oMouseClick); end
    check("wait_15", int'(oState), S_WAIT);
    idle();
    check("timeout_clear", int'(oState), S_CLEAR);
    check("timeout_strike", int'(oStrikes), 1);
    check("single_click", clickCount, 1);

    // Load timeout
    idle(); idle();
    repeat (LOAD_TIMEOUT - 1) idle();
    check("load_4095", int'(oState), S_LOAD);
    idle();
    check("load_timeout_clear", int'(oState), S_CLEAR);
    check("load_timeout_strikes", int'(oStrikes), 1);

    // Both verdicts together count as wrong
    loadBoard(1);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    check("num_1", int'(oNumToChoose), 1);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 1);
    check("both_strikes", int'(oStrikes), 2);
    check("both_num", int'(oNumToChoose), 1);
    check("both_state", int'(oState), S_CLEAR);

    // Reset while waiting for a verdict
    loadBoard(0);
    tick(0, 0, 1, 0, 0, 0);
    check("pre_rst_wait", int'(oState), S_WAIT);
    tick(1, 0, 0, 0, 0, 0);
    check("wait_rst_state", int'(oState), S_IDLE);
    check("wait_rst_strikes", int'(oStrikes), 0);
    check("wait_rst_num", int'(oNumToChoose), 0);

    // Perfect game through the last level, driven from the model's view
    tick(0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 5000 && mState != S_OVER; c++)
      tick(0, 0, mState == S_PLAY, mState == S_LOAD, mState == S_WAIT, 0);
    check("final_level", int'(oLevel), MAX_LEVEL);
    check("final_score", int'(oScore), MAX_LEVEL - START_LEVEL + 1);
    check("final_over", int'(oGameOver), 1);

    // Random stimulus
    for (int c = 0; c < 4000; c++)
      tick($urandom_range(399) == 0, $urandom_range(39) == 0,
           $urandom_range(2) == 0, $urandom_range(7) == 0,
           $urandom_range(3) == 0, $urandom_range(4) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
